stopwatch_mmss: RTL and testbench
=================================

STOPWATCH_MMSS -- requirements
Module: stopwatch_mmss

Interface
REQ-001 Parameter CLEAR_IN_RUN, default 0: 1 = clear honoured in RUN state; 0 = clear ignored in RUN.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 tick  input  1  one-cycle 1 Hz pulse from the 1 Hz clock divider, synchronous to clk.
REQ-005 start_stop  input  1  one-cycle pulse, already debounced; toggles run/pause.
REQ-006 clear  input  1  one-cycle pulse; zeroes count and returns to IDLE.
REQ-007 lap  input  1  one-cycle pulse; toggles display freeze.
REQ-008 sec_ones  output  4  BCD seconds units, 0-9.
REQ-009 sec_tens  output  4  BCD seconds tens, 0-5.
REQ-010 min_ones  output  4  BCD minutes units, 0-9.
REQ-011 min_tens  output  4  BCD minutes tens, 0-5.
REQ-012 running  output  1  high while state is RUN.
REQ-013 lap_active  output  1  high while display is frozen.
REQ-014 overflow  output  1  sticky flag, set on wrap 59:59 -> 00:00.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and PAUSE, encoded in registers.
REQ-016 IDLE + start_stop SHALL go to RUN; RUN + start_stop SHALL go to PAUSE; PAUSE + start_stop SHALL go to RUN.
REQ-017 clear in IDLE or PAUSE SHALL go to IDLE, zero the live count, lap_active and overflow, and clear the snapshot.
REQ-018 clear in RUN SHALL act as in REQ-017 when CLEAR_IN_RUN=1; when CLEAR_IN_RUN=0 it SHALL be ignored.
REQ-019 clear SHALL take priority over start_stop, lap and tick in the same cycle.
REQ-020 The live count SHALL increment by one second on a clk edge where tick=1 and the current (pre-edge) state is RUN; the new value SHALL be visible the following cycle.
REQ-021 tick coincident with RUN->PAUSE SHALL be counted; tick coincident with IDLE->RUN or PAUSE->RUN SHALL NOT be counted.
REQ-022 Carry chain: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0 is the wrap.
REQ-023 On wrap 59:59 -> 00:00 the count SHALL continue from 00:00, and overflow SHALL set and hold until clear or reset.
REQ-024 No BCD digit SHALL ever hold a value outside its stated range.
REQ-025 lap in RUN with lap_active=0 SHALL capture the live count into a snapshot register on that edge and set lap_active.
REQ-026 lap with lap_active=1, in RUN or PAUSE, SHALL clear lap_active.
REQ-027 lap in IDLE, or lap in PAUSE with lap_active=0, SHALL be ignored.
REQ-028 If lap capture coincides with a counted tick, the snapshot SHALL take the pre-increment value.
REQ-029 The digit outputs SHALL show the snapshot while lap_active=1 and the live count otherwise.
REQ-030 Counting SHALL continue unaffected while lap_active=1.
REQ-031 running SHALL equal (state==RUN); all outputs SHALL be driven from registers only, through the display mux.

Reset
REQ-032 rst low SHALL immediately, without waiting for clk, force state IDLE, zero the live count and snapshot, and drive all digit outputs, running, lap_active and overflow to 0.
REQ-033 Reset asserted mid-count SHALL discard the count.
REQ-034 After rst deasserts, the block SHALL stay in IDLE until the first start_stop pulse.

Verification
REQ-035 Reset, start_stop, then 75 ticks -> digits read 01:15, running=1, overflow=0.
REQ-036 Run to 59:58, then 2 ticks -> 59:59 then 00:00, overflow=1; clear while paused -> 00:00, overflow=0, state IDLE.
REQ-037 At 00:10 in RUN, pulse lap, then 5 ticks -> display holds 00:10, lap_active=1; pulse lap again -> display 00:15.
REQ-038 start_stop coincident with tick at 00:20 in RUN -> PAUSE and 00:21; further ticks -> no change; start_stop coincident with tick -> RUN and still 00:21.
REQ-039 CLEAR_IN_RUN=0: clear at 00:30 in RUN -> ignored, counting continues; CLEAR_IN_RUN=1: same stimulus -> 00:00, IDLE, running=0.
REQ-040 Assert rst between clk edges at 03:07 in RUN -> all outputs 0 with no clk edge; ticks after deassertion -> no change until start_stop.

Source files
------------

// File: rtl/stopwatch_mmss_if.sv
// Control pulses into the mm:ss stopwatch and its BCD display/status outputs.
// Suffixes are relative to the stopwatch: _i drives it, _o comes from it.
interface stopwatch_mmss_if;
    logic       tick_i;
    logic       start_stop_i;
    logic       clear_i;
    logic       lap_i;
    logic [3:0] sec_ones_o;
    logic [3:0] sec_tens_o;
    logic [3:0] min_ones_o;
    logic [3:0] min_tens_o;
    logic       running_o;
    logic       lap_active_o;
    logic       overflow_o;

    modport master (
        output tick_i, start_stop_i, clear_i, lap_i,
        input  sec_ones_o, sec_tens_o, min_ones_o, min_tens_o,
        input  running_o, lap_active_o, overflow_o
    );

    modport slave (
        input  tick_i, start_stop_i, clear_i, lap_i,
        output sec_ones_o, sec_tens_o, min_ones_o, min_tens_o,
        output running_o, lap_active_o, overflow_o
    );
endinterface

// File: rtl/stopwatch_mmss.sv
// mm:ss BCD stopwatch with run/pause FSM, lap freeze snapshot and sticky wrap flag.
// Digit index 0..3 = sec_ones, sec_tens, min_ones, min_tens.
module stopwatch_mmss #(
    parameter bit CLEAR_IN_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_mmss_if.slave  sw
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [15:0] DIGIT_MAX = 16'h5959;

    state_t           state_q, state_d;
    logic [3:0][3:0]  cnt_q, cnt_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic [3:0][3:0]  cnt_inc;
    logic             lap_q, lap_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       at_max;
    logic [4:0]       carry;
    logic             clear_hit;
    logic             count_en;

    assign clear_hit = sw.clear_i && ((state_q != RUN) || CLEAR_IN_RUN);
    assign count_en  = sw.tick_i && (state_q == RUN) && !clear_hit;
    assign carry[0]  = count_en;

    // A digit rolls to zero when it sits at (or, defensively, above) its limit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign at_max[gi]    = (cnt_q[gi] >= DIGIT_MAX[gi*4 +: 4]);
            assign carry[gi+1]   = count_en && (at_max[gi:0] == {(gi+1){1'b1}});
            assign cnt_inc[gi]   = !carry[gi] ? cnt_q[gi] :
                                   at_max[gi] ? 4'd0 : cnt_q[gi] + 4'd1;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        snap_d  = snap_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;

        if (clear_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
            snap_d  = '0;
            lap_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (carry[4]) begin
                ovf_d = 1'b1;
            end

            if (sw.start_stop_i) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end

            // Snapshot takes the pre-edge count, so a coincident tick is not captured.
            if (sw.lap_i) begin
                if (lap_q && (state_q != IDLE)) begin
                    lap_d = 1'b0;
                end else if (!lap_q && (state_q == RUN)) begin
                    lap_d  = 1'b1;
                    snap_d = cnt_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            lap_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sw.sec_ones_o   = lap_q ? snap_q[0] : cnt_q[0];
    assign sw.sec_tens_o   = lap_q ? snap_q[1] : cnt_q[1];
    assign sw.min_ones_o   = lap_q ? snap_q[2] : cnt_q[2];
    assign sw.min_tens_o   = lap_q ? snap_q[3] : cnt_q[3];
    assign sw.running_o    = (state_q == RUN);
    assign sw.lap_active_o = lap_q;
    assign sw.overflow_o   = ovf_q;
endmodule

// File: tb/tb_stopwatch_mmss.sv
// Drives two stopwatches (clear ignored / honoured in RUN) with identical pulses and
// compares each against a seconds-count reference model.
module tb_stopwatch_mmss;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    typedef struct {
        int st;
        int cnt;
        int snap;
        bit lapa;
        bit ovf;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    mdl_t m0, m1;

    always #10 clk = ~clk;

    stopwatch_mmss_if if0 ();
    stopwatch_mmss_if if1 ();

    stopwatch_mmss #(.CLEAR_IN_RUN(1'b0)) dut0 (.clk(clk), .rst(rst), .sw(if0));
    stopwatch_mmss #(.CLEAR_IN_RUN(1'b1)) dut1 (.clk(clk), .rst(rst), .sw(if1));

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = M_IDLE; r.cnt = 0; r.snap = 0; r.lapa = 1'b0; r.ovf = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit cir, bit t, bit ss, bit c, bit l);
        mdl_t n = m;
        if (c && (m.st != M_RUN || cir)) return mreset();
        if (t && m.st == M_RUN) begin
            n.cnt = (m.cnt + 1) % 3600;
            if (m.cnt == 3599) n.ovf = 1'b1;
        end
        if (l) begin
            if (m.lapa && m.st != M_IDLE) n.lapa = 1'b0;
            else if (!m.lapa && m.st == M_RUN) begin
                n.lapa = 1'b1;
                n.snap = m.cnt;
            end
        end
        if (ss) n.st = (m.st == M_RUN) ? M_PAUSE : M_RUN;
        return n;
    endfunction

    // Expected display word {min_tens, min_ones, sec_tens, sec_ones, running, lap, ovf}.
    function automatic logic [18:0] expect_word(mdl_t m);
        int s;
        s = m.lapa ? m.snap : m.cnt;
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10),
                m.st == M_RUN, m.lapa, m.ovf};
    endfunction

    task automatic cmp(string tag, logic [18:0] obs, logic [18:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check(string tag);
        cmp({tag, "/clr_ignored"},
            {if0.min_tens_o, if0.min_ones_o, if0.sec_tens_o, if0.sec_ones_o,
             if0.running_o, if0.lap_active_o, if0.overflow_o}, expect_word(m0));
        cmp({tag, "/clr_in_run"},
            {if1.min_tens_o, if1.min_ones_o, if1.sec_tens_o, if1.sec_ones_o,
             if1.running_o, if1.lap_active_o, if1.overflow_o}, expect_word(m1));
    endtask

    task automatic cycle(string tag, bit t, bit ss, bit c, bit l);
        if0.tick_i = t; if0.start_stop_i = ss; if0.clear_i = c; if0.lap_i = l;
        if1.tick_i = t; if1.start_stop_i = ss; if1.clear_i = c; if1.lap_i = l;
        @(posedge clk);
        m0 = mstep(m0, 1'b0, t, ss, c, l);
        m1 = mstep(m1, 1'b1, t, ss, c, l);
        #1;
        if0.tick_i = 0; if0.start_stop_i = 0; if0.clear_i = 0; if0.lap_i = 0;
        if1.tick_i = 0; if1.start_stop_i = 0; if1.clear_i = 0; if1.lap_i = 0;
        check(tag);
    endtask

    task automatic ticks(string tag, int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        if0.tick_i = 0; if0.start_stop_i = 0; if0.clear_i = 0; if0.lap_i = 0;
        if1.tick_i = 0; if1.start_stop_i = 0; if1.clear_i = 0; if1.lap_i = 0;
        m0 = mreset();
        m1 = mreset();

        // Reset state and idle behaviour
        repeat (2) @(posedge clk);
        #3;
        check("reset");
        rst = 1'b1;
        ticks("idle_tick", 3);

        // 75 ticks after start -> 01:15
        cycle("start", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks("run", 75);
        $display("step 01:15 reached, running=%0b", if0.running_o);

        // Up to 59:58, then wrap to 00:00 with overflow
        ticks("run_long", 3598 - 75);
        ticks("5959", 1);
        ticks("wrap", 1);
        ticks("after_wrap", 2);
        cycle("pause", 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("clear_paused", 1'b0, 1'b0, 1'b1, 1'b0);
        $display("step wrap and clear done");

        // Lap freeze: 00:10, lap, 5 ticks, lap again -> 00:15
        cycle("start2", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks("to10", 10);
        cycle("lap_on", 1'b0, 1'b0, 1'b0, 1'b1);
        ticks("lap_frozen", 5);
        cycle("lap_off", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("lap_tick_capture", 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("lap_tick_release", 1'b1, 1'b0, 1'b0, 1'b1);
        $display("step lap freeze done");

        // start_stop coincident with tick
        ticks("to20", 20 - m0.cnt);
        cycle("ss_tick_pause", 1'b1, 1'b1, 1'b0, 1'b0);
        ticks("paused", 3);
        cycle("lap_paused_ignored", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("ss_tick_resume", 1'b1, 1'b1, 1'b0, 1'b0);
        $display("step start_stop with tick done");

        // Clear during RUN: ignored on dut0, honoured on dut1
        ticks("to30", 30 - m0.cnt);
        cycle("clear_run", 1'b0, 1'b0, 1'b1, 1'b0);
        ticks("after_clear_run", 2);
        $display("step clear in run done");

        // Asynchronous reset between edges at 03:07 in RUN
        #9;
        rst = 1'b0;
        m0 = mreset();
        m1 = mreset();
        #1;
        check("to_reset_first");
        #20;
        rst = 1'b1;
        cycle("start3", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks("to307", 187);
        #5;
        rst = 1'b0;
        m0 = mreset();
        m1 = mreset();
        #1;
        check("async_reset");
        #20;
        rst = 1'b1;
        ticks("post_reset_idle", 4);
        cycle("start4", 1'b0, 1'b1, 1'b0, 1'b0);
        ticks("post_reset_run", 3);
        $display("step async reset done");

        // Random pulses against the model
        for (int i = 0; i < 3000; i++) begin
            cycle("random",
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 11) == 0));
        end
        $display("step random done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
